pair_scan_ctrl: RTL

Sequencer for the BGA continuity tester. It drives a walking-one pattern across the N_PAIR output/input pin pairs and waits a programmable settle time on each step. It then compares the synchronised sense vector against the driven pattern and reports each failing pair over a valid/ready record port. It replaces the free-running scan loop at the top level. Start, abort, per-pass statistics and a sticky fail flag are exposed for the LED/debug path.

---
 rtl/pair_scan_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pair_scan_ctrl.sv
// pair_scan_ctrl: walking-one continuity sequencer for the BGA tester.
// Drives one-hot(idx) on drive_o, holds it for SETTLE cycles, then compares the
// synchronised sense vector against the driven pattern. Each failing pair is
// reported over a valid/ready record port. Back-pressure on that port stalls the scan.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   start, continuous      begin a pass (ignored while busy); continuous latched with start
//   abort                  level; return to idle on the next edge from any state
//   drive_o / sense_i      output pin pattern (registered) / raw input pins
//   busy, done             not idle / one-cycle end-of-pass pulse
//   fail_valid/ready/idx/open/short   failure record handshake and fields
//   fail_cnt, sticky_fail  saturating failure count and sticky flag since last start
module pair_scan_ctrl #(
  parameter int unsigned N_PAIR = 86,
  parameter int unsigned IDX_W  = 7,
  parameter int unsigned SETTLE = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  output logic [N_PAIR-1:0] drive_o,
  input  logic [N_PAIR-1:0] sense_i,
  output logic              busy,
  output logic              done,
  output logic              fail_valid,
  input  logic              fail_ready,
  output logic [IDX_W-1:0]  fail_idx,
  output logic              fail_open,
  output logic              fail_short,
  output logic [7:0]        fail_cnt,
  output logic              sticky_fail
);

  typedef enum logic [2:0] {StIdle, StDrive, StSample, StReport, StNext, StDone} state_e;

  localparam logic [N_PAIR-1:0] One        = N_PAIR'(1);
  localparam logic [7:0]        SettleLoad = 8'(SETTLE - 1);
  localparam logic [IDX_W-1:0]  LastIdx    = IDX_W'(N_PAIR - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          settle_q, settle_d;
  logic                cont_q, cont_d;
  logic [N_PAIR-1:0]   drive_q, drive_d;
  logic [N_PAIR-1:0]   sync1_q, sense_s_q;
  logic                fv_q, fv_d;
  logic [IDX_W-1:0]    fidx_q, fidx_d;
  logic                fopen_q, fopen_d;
  logic                fshort_q, fshort_d;
  logic [7:0]          fcnt_q, fcnt_d;
  logic                sticky_q, sticky_d;

  logic [N_PAIR-1:0]   exp_pat;
  logic                pair_open, pair_short;

  assign exp_pat    = One << idx_q;
  assign pair_open  = ~|(sense_s_q & exp_pat);
  assign pair_short = |(sense_s_q & ~exp_pat);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    cont_d   = cont_q;
    fv_d     = fv_q;
    fidx_d   = fidx_q;
    fopen_d  = fopen_q;
    fshort_d = fshort_q;
    fcnt_d   = fcnt_q;
    sticky_d = sticky_q;

    if (abort) begin
      // Abort beats start and the record handshake; statistics are kept.
      state_d = StIdle;
      fv_d    = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            idx_d    = '0;
            fcnt_d   = '0;
            sticky_d = 1'b0;
            cont_d   = continuous;
            settle_d = SettleLoad;
            state_d  = StDrive;
          end
        end
        StDrive: begin
          if (settle_q == 8'd0) begin
            state_d = StSample;
          end else begin
            settle_d = settle_q - 8'd1;
          end
        end
        StSample: begin
          if (pair_open || pair_short) begin
            fcnt_d   = (fcnt_q == 8'hFF) ? 8'hFF : fcnt_q + 8'd1;
            sticky_d = 1'b1;
            fidx_d   = idx_q;
            fopen_d  = pair_open;
            fshort_d = pair_short;
            fv_d     = 1'b1;
            state_d  = StReport;
          end else begin
            state_d = StNext;
          end
        end
        StReport: begin
          if (fail_ready) begin
            fv_d    = 1'b0;
            state_d = StNext;
          end
        end
        StNext: begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            settle_d = SettleLoad;
            state_d  = StDrive;
          end
        end
        StDone: begin
          if (cont_q) begin
            idx_d    = '0;
            settle_d = SettleLoad;
            state_d  = StDrive;
          end else begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Pattern follows the next state so drive_o is registered yet aligned with it.
  always_comb begin
    drive_d = '0;
    case (state_d)
      StDrive, StSample, StReport, StNext: drive_d = One << idx_d;
      default:                             drive_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      settle_q  <= '0;
      cont_q    <= 1'b0;
      drive_q   <= '0;
      sync1_q   <= '0;
      sense_s_q <= '0;
      fv_q      <= 1'b0;
      fidx_q    <= '0;
      fopen_q   <= 1'b0;
      fshort_q  <= 1'b0;
      fcnt_q    <= '0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      settle_q  <= settle_d;
      cont_q    <= cont_d;
      drive_q   <= drive_d;
      sync1_q   <= sense_i;
      sense_s_q <= sync1_q;
      fv_q      <= fv_d;
      fidx_q    <= fidx_d;
      fopen_q   <= fopen_d;
      fshort_q  <= fshort_d;
      fcnt_q    <= fcnt_d;
      sticky_q  <= sticky_d;
    end
  end

  assign drive_o     = drive_q;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign fail_valid  = fv_q;
  assign fail_idx    = fidx_q;
  assign fail_open   = fopen_q;
  assign fail_short  = fshort_q;
  assign fail_cnt    = fcnt_q;
  assign sticky_fail = sticky_q;

endmodule
